// File: rtl/tbu_param.sv
// Parametrised Viterbi traceback unit: circular survivor buffer, one traceback per
// block of DEC_LEN new vectors, decoded bits streamed oldest-first over valid/ready.
module tbu_param #(
    parameter int K          = 4,
    parameter int TB_LEN     = 16,
    parameter int DEC_LEN    = 16,
    parameter int START_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2**(K-1)-1:0]  in_dec,
    input  logic [K-2:0]         start_state,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_bit,
    output logic                 out_last,
    output logic                 busy
);
    localparam int NUM_STATES = 2**(K-1);
    localparam int MEM_DEPTH  = TB_LEN + DEC_LEN;
    localparam int PW         = $clog2(MEM_DEPTH);
    localparam int CW         = $clog2(MEM_DEPTH + 1);
    localparam int LW         = $clog2(DEC_LEN + 1);

    localparam logic [PW-1:0] PTR_LAST  = PW'(MEM_DEPTH - 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(MEM_DEPTH - 1);
    localparam logic [CW-1:0] TB_CNT    = CW'(TB_LEN);
    localparam logic [LW-1:0] POP_LAST  = LW'(DEC_LEN - 1);

    typedef enum logic [1:0] {ST_FILL, ST_TRACE, ST_OUTPUT} state_t;

    state_t                  state_q;
    logic [NUM_STATES-1:0]   mem_q [MEM_DEPTH];
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_idx_q;
    logic [CW-1:0]           fill_cnt_q;
    logic [CW-1:0]           step_q;
    logic [K-2:0]            s_q;
    logic [DEC_LEN-1:0]      lifo_q;
    logic [LW-1:0]           pop_cnt_q;
    logic                    out_valid_q;
    logic                    out_bit_q;
    logic                    out_last_q;
    logic                    busy_q;

    logic                    xfer_s;
    logic [K-2:0]            s_d;
    logic [DEC_LEN-1:0]      lifo_pop_s;

    assign in_ready   = (state_q == ST_FILL) & en & ~rst;
    assign xfer_s     = in_valid & in_ready;
    // Predecessor state: shift the survivor decision in at the LSB.
    assign s_d        = {s_q[K-3:0], mem_q[rd_idx_q][s_q]};
    assign lifo_pop_s = lifo_q >> 1;

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

    // Survivor buffer write port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (xfer_s) begin
            mem_q[wr_ptr_q] <= in_dec;
        end
    end

    // Control FSM: fill, traceback, and output streaming with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            wr_ptr_q    <= '0;
            rd_idx_q    <= '0;
            fill_cnt_q  <= '0;
            step_q      <= '0;
            s_q         <= '0;
            lifo_q      <= '0;
            pop_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else if (!en) begin
            state_q     <= ST_FILL;
            wr_ptr_q    <= '0;
            rd_idx_q    <= '0;
            fill_cnt_q  <= '0;
            step_q      <= '0;
            s_q         <= '0;
            lifo_q      <= '0;
            pop_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (xfer_s) begin
                        wr_ptr_q   <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
                        fill_cnt_q <= fill_cnt_q + CW'(1);
                        if (fill_cnt_q == FILL_LAST) begin
                            state_q   <= ST_TRACE;
                            busy_q    <= 1'b1;
                            rd_idx_q  <= wr_ptr_q;
                            step_q    <= '0;
                            pop_cnt_q <= '0;
                            s_q       <= (START_MODE != 0) ? start_state : '0;
                        end
                    end
                end
                ST_TRACE: begin
                    if (step_q >= TB_CNT) begin
                        lifo_q <= (lifo_q << 1) | DEC_LEN'(s_q[K-2]);
                    end
                    s_q      <= s_d;
                    rd_idx_q <= (rd_idx_q == '0) ? PTR_LAST : rd_idx_q - PW'(1);
                    step_q   <= step_q + CW'(1);
                    if (step_q == FILL_LAST) begin
                        state_q <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_bit_q   <= lifo_q[0];
                        out_last_q  <= (pop_cnt_q == POP_LAST);
                    end else if (out_ready) begin
                        lifo_q    <= lifo_pop_s;
                        pop_cnt_q <= pop_cnt_q + LW'(1);
                        if (out_last_q) begin
                            // Keep the newest TB_LEN vectors as merge history for the next block.
                            state_q     <= ST_FILL;
                            fill_cnt_q  <= TB_CNT;
                            pop_cnt_q   <= '0;
                            out_valid_q <= 1'b0;
                            out_bit_q   <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            out_bit_q  <= lifo_pop_s[0];
                            out_last_q <= ((pop_cnt_q + LW'(1)) == POP_LAST);
                        end
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end
endmodule
